// File: rtl/mem_bus_responder.sv
// Memory-side responder on the shared tri-state CPU bus: zero-latency reads and once-per-request stores.
// Optional access counters are enabled by defining MEMBUS_STATS_EN.
`timescale 1ns/1ps
module mem_bus_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE       = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] BUS,
  input  logic        Memread,
  input  logic [1:0]  Memwrite,
  input  logic [31:0] Addr,
  output logic        sel,
  output logic        bus_err,
  output logic        oor_err,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  localparam int unsigned WORDS = 2 ** DEPTH_LOG2;
  localparam logic [32:0] SPAN  = 33'(2 * WORDS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [31:0]           mem [WORDS];
  logic [32:0]           offset;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  wr_req;
  logic                  conflict;
  logic                  rd_drive;
  logic                  new_req;
  logic                  commit_raw;
  logic                  commit;
  logic [31:0]           wdata;

  logic [0:0]            state;
  logic [0:0]            state_nxt;
  logic [31:0]           last_addr;
  logic [1:0]            last_we;

  // Widened subtraction: an Addr below BASE wraps to a huge offset and falls out of range.
  assign offset   = {1'b0, Addr} - {1'b0, BASE};
  assign sel      = (offset < SPAN);
  assign idx      = offset[DEPTH_LOG2:1];

  assign wr_req   = (Memwrite != 2'd0);
  assign conflict = Memread && wr_req;
  assign rd_drive = Memread && !wr_req && sel && !rst;

  assign BUS = rd_drive ? mem[idx] : 'z;

  assign new_req = (Addr != last_addr) || (Memwrite != last_we);

  always_comb begin
    commit_raw = 1'b0;
    state_nxt  = state;
    if (!conflict) begin
      case (state)
        IDLE: begin
          if (wr_req && sel) begin
            commit_raw = 1'b1;
            state_nxt  = HOLD;
          end
        end
        HOLD: begin
          if (!wr_req)
            state_nxt = IDLE;
          else if (new_req)
            commit_raw = sel;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A store whose edge falls inside reset is dropped.
  assign commit = commit_raw && !rst;

  assign wdata = (Memwrite == 2'd3) ? {mem[idx][31:16], BUS[15:0]} : BUS;

  always_ff @(posedge clk) begin
    if (commit)
      mem[idx] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_addr <= '0;
      last_we   <= '0;
      bus_err   <= 1'b0;
      oor_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!conflict && wr_req) begin
        last_addr <= Addr;
        last_we   <= Memwrite;
      end
      if (conflict)
        bus_err <= 1'b1;
      if ((Memread || wr_req) && !sel)
        oor_err <= 1'b1;
    end
  end

`ifdef MEMBUS_STATS_EN
  logic        rd_prev;
  logic [15:0] rd_q;
  logic [15:0] wr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_prev <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      rd_prev <= Memread;
      if (Memread && !rd_prev && sel)
        rd_q <= rd_q + 16'd1;
      if (commit)
        wr_q <= wr_q + 16'd1;
    end
  end

  assign rd_cnt = rd_q;
  assign wr_cnt = wr_q;
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: reads push expected data, the sampled BUS pops and compares.
// The bench drives 0 onto BUS wherever the responder must stay off it, so any responder drive shows up.
`timescale 1ns/1ps
module tb_mem_bus_responder;

  localparam int unsigned DL   = 10;
  localparam logic [31:0] BASE = 32'd0;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        Memread  = 1'b0;
  logic [1:0]  Memwrite = 2'd0;
  logic [31:0] Addr     = 32'd0;
  logic        drv_en   = 1'b0;
  logic [31:0] drv_d    = 32'd0;
  wire  [31:0] BUS;
  logic        sel;
  logic        bus_err;
  logic        oor_err;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  assign BUS = drv_en ? drv_d : 'z;

  always #5 clk = ~clk;

  mem_bus_responder #(.DEPTH_LOG2(DL), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .BUS(BUS), .Memread(Memread), .Memwrite(Memwrite),
    .Addr(Addr), .sel(sel), .bus_err(bus_err), .oor_err(oor_err),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [31:0] model [2**DL];
  logic [15:0] m_rd = 16'd0;
  logic [15:0] m_wr = 16'd0;
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  function automatic logic [15:0] cnt_exp(input logic [15:0] v);
`ifdef MEMBUS_STATS_EN
    return v;
`else
    return v & 16'h0;
`endif
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE};
    return off < 33'(2 * (2 ** DL));
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[DL:1]);
  endfunction

  task automatic model_commit(input logic [1:0] we, input logic [31:0] a, input logic [31:0] d);
    int unsigned i;
    i = widx(a);
    if (we == 2'd3) model[i] = {model[i][31:16], d[15:0]};
    else            model[i] = d;
    m_wr++;
  endtask

  task automatic do_write(input logic [1:0] we, input logic [31:0] a, input logic [31:0] d,
                          input int unsigned cyc);
    Memwrite = we; Addr = a; drv_en = 1'b1; drv_d = d;
    repeat (cyc) @(negedge clk);
    Memwrite = 2'd0; drv_en = 1'b0;
    @(negedge clk);
    if (in_range(a)) model_commit(we, a, d);
  endtask

  task automatic do_b2b(input logic [1:0] we1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic [1:0] we2, input logic [31:0] a2, input logic [31:0] d2);
    Memwrite = we1; Addr = a1; drv_en = 1'b1; drv_d = d1;
    @(negedge clk);
    Memwrite = we2; Addr = a2; drv_d = d2;
    repeat (2) @(negedge clk);
    Memwrite = 2'd0; drv_en = 1'b0;
    @(negedge clk);
    model_commit(we1, a1, d1);
    model_commit(we2, a2, d2);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a);
    Memread = 1'b1; Addr = a;
    if (in_range(a)) begin
      drv_en = 1'b0;
      exp_q.push_back(model[widx(a)]);
    end else begin
      drv_en = 1'b1; drv_d = 32'd0;
      exp_q.push_back(32'd0);
    end
    #2;
    chk({tag, "_sel"}, 32'(sel), 32'(in_range(a)));
    chk(tag, BUS, exp_q.pop_front());
    @(negedge clk);
    Memread = 1'b0; drv_en = 1'b0;
    if (in_range(a)) m_rd++;
    @(negedge clk);
  endtask

  task automatic check_z(input string tag);
    drv_en = 1'b1; drv_d = 32'd0;
    #1;
    chk(tag, BUS, 32'd0);
    drv_en = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(cnt_exp(m_rd)));
    chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(cnt_exp(m_wr)));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_oor_err", 32'(oor_err), 32'd0);
    check_stats("rst");
    check_z("rst_bus_z");
    rst = 1'b0;
    @(negedge clk);

    // Read path: preload, zero-latency read, release, bit0 ignored
    do_write(2'd1, 32'd6, 32'hDEADBEEF, 2);
    do_read("t1_rd", 32'd6);
    check_z("t1_idle_z");
    do_read("t1_rd_odd", 32'd7);

    // Held word store commits once
    do_write(2'd1, 32'd8, 32'h12345678, 4);
    check_stats("t2");
    do_read("t2_rd", 32'd8);

    // Half store keeps the upper half
    do_write(2'd3, 32'd8, 32'hFFFFABCD, 2);
    do_read("t3_rd", 32'd8);

    // Back-to-back by address change, then by Memwrite change, then a DMA store
    do_b2b(2'd1, 32'd10, 32'hA1A1A1A1, 2'd1, 32'd12, 32'hB2B2B2B2);
    check_stats("t4");
    do_read("t4_rd10", 32'd10);
    do_read("t4_rd12", 32'd12);
    do_b2b(2'd1, 32'd16, 32'h00001111, 2'd3, 32'd16, 32'hFFFF2222);
    do_read("t4_rd16", 32'd16);
    do_write(2'd2, 32'd14, 32'h5A5A0F0F, 1);
    do_read("t4_dma", 32'd14);
    check_stats("t4b");
    chk("t4_bus_err", 32'(bus_err), 32'd0);

    // Conflict: no commit, responder stays off the bus
    Memread = 1'b1; Memwrite = 2'd1; Addr = 32'd6; drv_en = 1'b1; drv_d = 32'd0;
    #2;
    chk("t5_conf_bus", BUS, 32'd0);
    repeat (2) @(negedge clk);
    Memread = 1'b0; Memwrite = 2'd0; drv_en = 1'b0;
    @(negedge clk);
    m_rd++;
    chk("t5_bus_err", 32'(bus_err), 32'd1);
    do_read("t5_rd_unchanged", 32'd6);
    check_stats("t5");

    // Range boundary: last word in range, then first address beyond it
    do_write(2'd1, 32'd2046, 32'h0BADF00D, 1);
    do_read("t5_rd_last", 32'd2047);
    chk("t5_oor_before", 32'(oor_err), 32'd0);
    do_read("t5_rd_oor", 32'd2048);
    chk("t5_oor_err", 32'(oor_err), 32'd1);
    check_stats("t5b");

    // Reset during a held store that is dropped before release
    do_write(2'd1, 32'd20, 32'h11111111, 1);
    Memwrite = 2'd1; Addr = 32'd20; drv_en = 1'b1; drv_d = 32'h22222222;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    m_rd = 16'd0; m_wr = 16'd0;
    chk("t6_bus_err", 32'(bus_err), 32'd0);
    chk("t6_oor_err", 32'(oor_err), 32'd0);
    check_stats("t6_in_rst");
    Memwrite = 2'd0; drv_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_read("t6_rd_dropped", 32'd20);

    // Reset released with the store still held: exactly one commit
    Memwrite = 2'd1; Addr = 32'd20; drv_en = 1'b1; drv_d = 32'h33333333;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_rd = 16'd0; m_wr = 16'd0;
    repeat (4) @(negedge clk);
    Memwrite = 2'd0; drv_en = 1'b0;
    @(negedge clk);
    model_commit(2'd1, 32'd20, 32'h33333333);
    check_stats("t6_after");
    do_read("t6_rd_held", 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
